agc_shift_ctrl: RTL
===================

Name: agc_shift_ctrl

Overview:
Parametrised per-channel automatic gain stage for the TDM filter-output stream (FIR results tagged with a channel index). It arithmetically right-shifts each sample by that channel's shift, saturates to OUT_WIDTH and forwards it with its channel tag. It adapts each shift independently using a hysteresis counter pair and a cycle-count window, with auto, freeze and manual modes. It is the generalised successor of the fixed-13-channel fracshift logic and sits between the FIR and the output FIFO/DMA.

Parameters:
NUM_CHANS, 13, number of TDM channels (1..256)
IN_WIDTH, 48, signed input sample width
OUT_WIDTH, 16, signed output sample width (< IN_WIDTH)
CHAN_W, 8, channel tag width
SHIFT_W, 5, shift register width; MAX_SHIFT = 2^SHIFT_W-1
INIT_SHIFT, 0, shift value loaded on reset

Ports:
aclk  in  1  clock
areset  in  1  reset, synchronous, active-high
mode  in  2  00 auto, 01 freeze, 10 manual, 11 = freeze
man_shift  in  SHIFT_W  shift forced on all channels in manual mode
low_hold  in  32  consecutive low samples before decrement; 0 disables decrement
high_limit  in  16  high samples per window before increment; 0 treated as 1
window_len  in  32  window length in aclk cycles; 0 disables window clearing
s_tvalid  in  1  input sample valid (no backpressure)
s_tdata  in  IN_WIDTH  signed input sample
s_tuser  in  CHAN_W  channel index
m_tvalid  out  1  output valid
m_tdata  out  OUT_WIDTH  shifted, saturated sample
m_tuser  out  CHAN_W  channel index
shifts  out  NUM_CHANS*8  per-channel shift, zero-extended, channel c at [8c+:8]
sat_flags  out  NUM_CHANS  per-channel sticky saturation flag, cleared at window wrap

Behaviour:
- Reset (areset high at posedge): all shifts = INIT_SHIFT; all counters, window counter, sat_flags = 0; m_tvalid = 0, m_tdata = 0, m_tuser = 0. Mid-stream reset discards in-flight samples; m_tvalid = 0 the next cycle.
- Pipeline, fixed 2-cycle latency, one sample per cycle sustained:
  - S1: if s_tvalid and s_tuser < NUM_CHANS, capture x = s_tdata >>> shift[s_tuser] (IN_WIDTH arithmetic); a tag >= NUM_CHANS is dropped, producing no output and no counter effect.
  - S2: lo = |x| < 2^(OUT_WIDTH-2) (fits OUT_WIDTH-1 bits signed); hi = x > 2^(OUT_WIDTH-1)-1 or x < -2^(OUT_WIDTH-1). m_tdata = x saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; m_tvalid, m_tuser follow.
- Adaptation on each valid S2 sample of channel c (auto mode only):
  - lo: lowcnt[c]++; if low_hold != 0 and lowcnt[c]+1 >= low_hold, then shift[c]-- (clamped at 0) and lowcnt[c] = 0. Non-lo sample: lowcnt[c] = 0.
  - hi: sat_flags[c] = 1; if highcnt[c]+1 >= max(high_limit,1), then shift[c]++ (clamped at MAX_SHIFT), highcnt[c] = 0, lowcnt[c] = 0; else highcnt[c]++.
  - lo and hi are mutually exclusive, so an increment and a decrement never occur on the same sample.
- Shift update timing: a new shift is visible to samples entering S1 on the cycle after the S2 update. A sample already in S1 uses the old value.
- Window counter: runs every cycle regardless of valid. When window_len != 0 and count == window_len-1, it wraps to 0 and clears all highcnt and sat_flags. The clear takes priority over a same-cycle highcnt increment or sat_flag set, but a same-cycle shift increment still applies.
- Freeze mode: shifts held; lowcnt and highcnt held at 0; sat_flags still set; data path unchanged.
- Manual mode: every cycle, all shifts = man_shift and lowcnt/highcnt = 0. On return to auto, adaptation starts from man_shift.
- Mode is sampled every cycle; a change takes effect on the next posedge.

Test Plan:
- Auto increment: shift 0, high_limit 4, five ch0 samples of 40000 -> m_tdata 32767 four times, shifts[0] = 1 after the 4th, 5th output 20000, sat_flags[0] = 1.
- Auto decrement: INIT_SHIFT 3, low_hold 10, ch2 stream of 1000 -> outputs 125 x10, 250 x10, 500 x10, then 1000 indefinitely; shifts[2] ends at 0 and never underflows.
- Arithmetic and saturation: ch1 shift 1: -3 -> -2; shift 0: -100000 -> -32768; with shift 31 sustained 2^47-1 inputs -> shift stays 31.
- Window: window_len 100, high_limit 5; 3 hi samples, wrap, 3 hi samples -> no increment, sat_flags cleared at wrap. Hi sample on the wrap cycle completing high_limit -> shift increments, highcnt = 0.
- Modes: mode 10, man_shift 7 -> all shifts 7 one cycle later. Mode 01 with 100 hi samples -> shifts unchanged, sat_flags set.
- Edge cases: tag 13 with NUM_CHANS 13 -> no m_tvalid. Back-to-back same-channel hi samples: a sample already in S1 when the increment fires uses the old shift. areset mid-stream -> m_tvalid 0 next cycle, shifts = INIT_SHIFT.

Source files
------------

// File: rtl/agc_shift_ctrl.sv
// agc_shift_ctrl: per-channel arithmetic right shift with saturation and hysteresis-driven
// gain adaptation for a TDM sample stream (auto / freeze / manual modes).
module agc_shift_ctrl #(
  parameter int NUM_CHANS  = 13,
  parameter int IN_WIDTH   = 48,
  parameter int OUT_WIDTH  = 16,
  parameter int CHAN_W     = 8,
  parameter int SHIFT_W    = 5,
  parameter int INIT_SHIFT = 0
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [1:0]                  mode,
  input  logic [SHIFT_W-1:0]          man_shift,
  input  logic [31:0]                 low_hold,
  input  logic [15:0]                 high_limit,
  input  logic [31:0]                 window_len,
  input  logic                        s_tvalid,
  input  logic signed [IN_WIDTH-1:0]  s_tdata,
  input  logic [CHAN_W-1:0]           s_tuser,
  output logic                        m_tvalid,
  output logic signed [OUT_WIDTH-1:0] m_tdata,
  output logic [CHAN_W-1:0]           m_tuser,
  output logic [NUM_CHANS*8-1:0]      shifts,
  output logic [NUM_CHANS-1:0]        sat_flags
);
  localparam logic signed [IN_WIDTH-1:0] SAT_HI = {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = ~SAT_HI;
  localparam logic signed [IN_WIDTH-1:0] LO_POS = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-2){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] LO_NEG = ~LO_POS;
  logic                       v1;
  logic signed [IN_WIDTH-1:0] x1;
  logic [CHAN_W-1:0]          c1;
  logic [SHIFT_W-1:0]         shift_r [NUM_CHANS];
  logic [SHIFT_W-1:0]         shift_nx [NUM_CHANS];
  logic [31:0]                low_r [NUM_CHANS];
  logic [31:0]                low_nx [NUM_CHANS];
  logic [15:0]                high_r [NUM_CHANS];
  logic [15:0]                high_nx [NUM_CHANS];
  logic [NUM_CHANS-1:0]       sat_nx, hit;
  logic [SHIFT_W-1:0]         cur_shift;
  logic [31:0]                wcnt;
  logic [16:0]                hl_eff;
  logic                       wrap, lo, hi, in_ok, manual, freeze;
  assign in_ok  = 32'(s_tuser) < NUM_CHANS;
  assign lo     = (x1 <= LO_POS) && (x1 > LO_NEG);
  assign hi     = (x1 > SAT_HI) || (x1 < SAT_LO);
  assign wrap   = (window_len != 32'd0) && (wcnt == window_len - 32'd1);
  assign hl_eff = high_limit == 16'd0 ? 17'd1 : 17'(high_limit);
  assign manual = mode == 2'b10;
  assign freeze = mode[0];
  always_comb begin
    cur_shift = '0;
    for (int c = 0; c < NUM_CHANS; c++) cur_shift = s_tuser == CHAN_W'(c) ? shift_r[c] : cur_shift;
  end
  always_comb begin
    for (int c = 0; c < NUM_CHANS; c++) begin
      hit[c]      = v1 && c1 == CHAN_W'(c);
      shift_nx[c] = shift_r[c];
      low_nx[c]   = low_r[c];
      high_nx[c]  = high_r[c];
      sat_nx[c]   = sat_flags[c] | (hit[c] & hi);
      if (manual) begin
        shift_nx[c] = man_shift;
        low_nx[c]   = '0;
        high_nx[c]  = '0;
      end else if (freeze) begin
        low_nx[c]  = '0;
        high_nx[c] = '0;
      end else if (hit[c]) begin
        low_nx[c] = lo ? low_r[c] + 32'd1 : '0;
        if (lo && low_hold != 32'd0 && 33'(low_r[c]) + 33'd1 >= 33'(low_hold)) begin
          shift_nx[c] = shift_r[c] == '0 ? shift_r[c] : shift_r[c] - 1'b1;
          low_nx[c]   = '0;
        end
        if (hi && 17'(high_r[c]) + 17'd1 >= hl_eff) begin
          shift_nx[c] = &shift_r[c] ? shift_r[c] : shift_r[c] + 1'b1;
          high_nx[c]  = '0;
          low_nx[c]   = '0;
        end else if (hi) begin
          high_nx[c] = high_r[c] + 16'd1;
        end
      end
      // window wrap wins over a same-cycle count/flag update, but not over a shift step
      high_nx[c] = wrap ? '0 : high_nx[c];
      sat_nx[c]  = wrap ? 1'b0 : sat_nx[c];
    end
  end
  always_comb begin
    shifts = '0;
    for (int c = 0; c < NUM_CHANS; c++) shifts[8*c +: 8] = 8'(shift_r[c]);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int c = 0; c < NUM_CHANS; c++) begin
        shift_r[c] <= SHIFT_W'(INIT_SHIFT);
        low_r[c]   <= '0;
        high_r[c]  <= '0;
      end
      sat_flags <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANS; c++) begin
        shift_r[c] <= shift_nx[c];
        low_r[c]   <= low_nx[c];
        high_r[c]  <= high_nx[c];
      end
      sat_flags <= sat_nx;
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      v1       <= 1'b0;
      x1       <= '0;
      c1       <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= '0;
      wcnt     <= '0;
    end else begin
      v1       <= s_tvalid && in_ok;
      x1       <= s_tdata >>> cur_shift;
      c1       <= s_tuser;
      m_tvalid <= v1;
      m_tdata  <= hi ? (x1[IN_WIDTH-1] ? SAT_LO[OUT_WIDTH-1:0] : SAT_HI[OUT_WIDTH-1:0]) : x1[OUT_WIDTH-1:0];
      m_tuser  <= c1;
      wcnt     <= wrap ? '0 : wcnt + 32'd1;
    end
  end
endmodule
